// File: rtl/mem_setup_ctrl.sv
// Host-side setup/verify controller for the core's dual-port memory (port B).
// Writes and read-back-compares host words, and gates the core enable between setup and run.
module mem_setup_ctrl #(
    parameter int DATAPATH_WIDTH  = 64,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        host_valid,
    output logic                        host_ready,
    input  logic                        host_write,
    input  logic [MEM_ADDR_WIDTH-1:0]   host_addr,
    input  logic [DATAPATH_WIDTH-1:0]   host_data,
    input  logic                        run_req,
    input  logic                        halt_req,
    input  logic                        err_clr,
    output logic [MEM_ADDR_WIDTH-1:0]   memb_addr,
    output logic [DATAPATH_WIDTH-1:0]   memb_din,
    output logic                        memb_we,
    input  logic [DATAPATH_WIDTH-1:0]   memb_dout,
    output logic                        core_en,
    output logic                        rsp_valid,
    output logic [DATAPATH_WIDTH-1:0]   rsp_data,
    output logic                        rsp_match,
    output logic [ERR_COUNT_WIDTH-1:0]  err_count,
    output logic [MEM_ADDR_WIDTH:0]     wr_count,
    output logic                        busy
);

    typedef enum logic [2:0] {IDLE, WR, RD, CMP, RUN} state_t;

    localparam logic [MEM_ADDR_WIDTH:0] WR_MAX = {1'b1, {MEM_ADDR_WIDTH{1'b0}}};

    state_t                      state;
    logic [DATAPATH_WIDTH-1:0]   exp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            host_ready <= 1'b1;
            memb_addr  <= '0;
            memb_din   <= '0;
            memb_we    <= 1'b0;
            core_en    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_match  <= 1'b0;
            err_count  <= '0;
            wr_count   <= '0;
            busy       <= 1'b0;
            exp_data   <= '0;
        end else begin
            memb_we   <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A run_req arriving with a command is dropped, not queued.
                    if (host_valid) begin
                        memb_addr  <= host_addr;
                        host_ready <= 1'b0;
                        busy       <= 1'b1;
                        if (host_write) begin
                            memb_din <= host_data;
                            memb_we  <= 1'b1;
                            state    <= WR;
                        end else begin
                            exp_data <= host_data;
                            state    <= RD;
                        end
                    end else if (run_req) begin
                        core_en    <= 1'b1;
                        host_ready <= 1'b0;
                        state      <= RUN;
                    end
                end
                WR: begin
                    if (wr_count != WR_MAX)
                        wr_count <= wr_count + 1'b1;
                    host_ready <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                RD: state <= CMP;
                CMP: begin
                    rsp_data  <= memb_dout;
                    rsp_match <= (memb_dout == exp_data);
                    rsp_valid <= 1'b1;
                    if ((memb_dout != exp_data) && (err_count != '1))
                        err_count <= err_count + 1'b1;
                    host_ready <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                RUN: begin
                    if (halt_req) begin
                        core_en    <= 1'b0;
                        host_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    core_en    <= 1'b0;
                    host_ready <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
            // Clear takes priority over a same-cycle mismatch increment.
            if (err_clr)
                err_count <= '0;
        end
    end

endmodule

// File: tb/tb_mem_setup_ctrl.sv
// Directed bench for mem_setup_ctrl with a synchronous-read port B memory model.
// A second instance with a narrow error counter exercises counter saturation quickly.
module tb_mem_setup_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_valid = 1'b0;
    logic        host_write = 1'b0;
    logic [9:0]  host_addr = '0;
    logic [63:0] host_data = '0;
    logic        run_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        err_clr = 1'b0;
    logic [63:0] memb_dout;

    logic        host_ready, memb_we, core_en, rsp_valid, rsp_match, busy;
    logic [9:0]  memb_addr;
    logic [63:0] memb_din, rsp_data;
    logic [15:0] err_count;
    logic [10:0] wr_count;

    logic        s_host_ready, s_memb_we, s_core_en, s_rsp_valid, s_rsp_match, s_busy;
    logic [9:0]  s_memb_addr;
    logic [63:0] s_memb_din, s_rsp_data;
    logic [3:0]  s_err_count;
    logic [10:0] s_wr_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memb_we) mem[memb_addr] <= memb_din;
        memb_dout <= mem[memb_addr];
    end

    mem_setup_ctrl #(.DATAPATH_WIDTH(64), .MEM_ADDR_WIDTH(10), .ERR_COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
        .host_write(host_write), .host_addr(host_addr), .host_data(host_data),
        .run_req(run_req), .halt_req(halt_req), .err_clr(err_clr),
        .memb_addr(memb_addr), .memb_din(memb_din), .memb_we(memb_we), .memb_dout(memb_dout),
        .core_en(core_en), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_match(rsp_match),
        .err_count(err_count), .wr_count(wr_count), .busy(busy)
    );

    mem_setup_ctrl #(.DATAPATH_WIDTH(64), .MEM_ADDR_WIDTH(10), .ERR_COUNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(s_host_ready),
        .host_write(host_write), .host_addr(host_addr), .host_data(host_data),
        .run_req(run_req), .halt_req(halt_req), .err_clr(err_clr),
        .memb_addr(s_memb_addr), .memb_din(s_memb_din), .memb_we(s_memb_we), .memb_dout(memb_dout),
        .core_en(s_core_en), .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_match(s_rsp_match),
        .err_count(s_err_count), .wr_count(s_wr_count), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Accept in the current cycle; returns two cycles later with the controller back in IDLE.
    task automatic do_write(input logic [9:0] a, input logic [63:0] d);
        host_valid = 1'b1; host_write = 1'b1; host_addr = a; host_data = d;
        step();
        host_valid = 1'b0;
        step();
    endtask

    // Accept in the current cycle; returns in the cycle where rsp_valid is expected.
    task automatic do_verify(input logic [9:0] a, input logic [63:0] e);
        host_valid = 1'b1; host_write = 1'b0; host_addr = a; host_data = e;
        step();
        host_valid = 1'b0;
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  64'(host_ready), 64'd1);
        check({tag, "_we"},     64'(memb_we),    64'd0);
        check({tag, "_core"},   64'(core_en),    64'd0);
        check({tag, "_rspv"},   64'(rsp_valid),  64'd0);
        check({tag, "_busy"},   64'(busy),       64'd0);
        check({tag, "_addr"},   64'(memb_addr),  64'd0);
        check({tag, "_din"},    memb_din,        64'd0);
        check({tag, "_rdata"},  rsp_data,        64'd0);
        check({tag, "_errc"},   64'(err_count),  64'd0);
        check({tag, "_wrc"},    64'(wr_count),   64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        #2 reset = 1'b0;
        #1 check_reset_outputs("rst");
        step(); step();
        reset = 1'b1;
        step();

        // Write then verify
        host_valid = 1'b1; host_write = 1'b1; host_addr = 10'h005; host_data = 64'hDEADBEEF_01234567;
        step();
        host_valid = 1'b0;
        check("wr_we_n1",    64'(memb_we),    64'd1);
        check("wr_addr_n1",  64'(memb_addr),  64'h005);
        check("wr_din_n1",   memb_din,        64'hDEADBEEF_01234567);
        check("wr_ready_n1", 64'(host_ready), 64'd0);
        check("wr_busy_n1",  64'(busy),       64'd1);
        step();
        check("wr_we_n2",    64'(memb_we),    64'd0);
        check("wr_ready_n2", 64'(host_ready), 64'd1);
        check("wr_count_1",  64'(wr_count),   64'd1);
        host_valid = 1'b1; host_write = 1'b0; host_addr = 10'h005; host_data = 64'hDEADBEEF_01234567;
        step();
        host_valid = 1'b0;
        check("vf_addr_n1",  64'(memb_addr),  64'h005);
        check("vf_we_n1",    64'(memb_we),    64'd0);
        check("vf_rspv_n1",  64'(rsp_valid),  64'd0);
        step();
        check("vf_rspv_n2",  64'(rsp_valid),  64'd0);
        check("vf_ready_n2", 64'(host_ready), 64'd0);
        step();
        check("vf_rspv_n3",  64'(rsp_valid),  64'd1);
        check("vf_match",    64'(rsp_match),  64'd1);
        check("vf_rdata",    rsp_data,        64'hDEADBEEF_01234567);
        check("vf_ready_n3", 64'(host_ready), 64'd1);
        check("vf_errc",     64'(err_count),  64'd0);
        step();
        check("vf_rspv_n4",  64'(rsp_valid),  64'd0);

        // Mismatch, then clear coinciding with a second mismatch
        do_write(10'h3FF, 64'h1);
        do_verify(10'h3FF, 64'h2);
        check("mm_rspv",  64'(rsp_valid), 64'd1);
        check("mm_match", 64'(rsp_match), 64'd0);
        check("mm_rdata", rsp_data,       64'h1);
        check("mm_errc",  64'(err_count), 64'd1);
        err_clr = 1'b1;
        do_verify(10'h3FF, 64'h3);
        err_clr = 1'b0;
        check("clr_rspv", 64'(rsp_valid), 64'd1);
        check("clr_errc", 64'(err_count), 64'd0);
        step();

        // Run with a command held off, then halt
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("run_core",  64'(core_en),    64'd1);
        check("run_ready", 64'(host_ready), 64'd0);
        check("run_busy",  64'(busy),       64'd0);
        host_valid = 1'b1; host_write = 1'b1; host_addr = 10'h010; host_data = 64'hAA;
        for (int i = 0; i < 5; i++) begin
            step();
            check("run_hold_core",  64'(core_en),    64'd1);
            check("run_hold_ready", 64'(host_ready), 64'd0);
            check("run_hold_we",    64'(memb_we),    64'd0);
        end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_core",  64'(core_en),    64'd0);
        check("halt_ready", 64'(host_ready), 64'd1);
        step();
        host_valid = 1'b0;
        check("halt_acc_we",   64'(memb_we),   64'd1);
        check("halt_acc_addr", 64'(memb_addr), 64'h010);
        step();
        check("halt_wrc", 64'(wr_count), 64'd3);

        // host_valid beats run_req; run_req is dropped
        host_valid = 1'b1; host_write = 1'b1; host_addr = 10'h020; host_data = 64'h55; run_req = 1'b1;
        step();
        host_valid = 1'b0; run_req = 1'b0;
        check("pri_we",    64'(memb_we), 64'd1);
        check("pri_core1", 64'(core_en), 64'd0);
        step();
        check("pri_core2", 64'(core_en),    64'd0);
        check("pri_ready", 64'(host_ready), 64'd1);
        step();
        check("pri_core3", 64'(core_en),  64'd0);
        check("pri_wrc",   64'(wr_count), 64'd4);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("pri_run", 64'(core_en), 64'd1);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("pri_halt", 64'(core_en), 64'd0);

        // Async reset while in RD
        host_valid = 1'b1; host_write = 1'b0; host_addr = 10'h005; host_data = 64'hDEADBEEF_01234567;
        step();
        host_valid = 1'b0;
        check("ar_busy_pre", 64'(busy), 64'd1);
        #1 reset = 1'b0;
        #1 check_reset_outputs("ar");
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_no_rsp", 64'(rsp_valid),  64'd0);
            check("ar_idle",   64'(host_ready), 64'd1);
        end

        // Async reset while running drops core_en without a clock
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("ar_run_core", 64'(core_en), 64'd1);
        #1 reset = 1'b0;
        #1 check("ar_run_core0", 64'(core_en), 64'd0);
        check("ar_run_ready", 64'(host_ready), 64'd1);
        step();
        reset = 1'b1;
        step();

        // Write counter saturation
        for (int i = 0; i < 1024; i++) do_write(10'(i), 64'(i));
        check("sat_wr_1024", 64'(wr_count), 64'd1024);
        do_write(10'h000, 64'h0);
        check("sat_wr_1025", 64'(wr_count), 64'd1024);

        // Error counter saturation on the narrow-counter instance
        for (int i = 0; i < 15; i++) do_verify(10'h000, 64'h1);
        check("sat_err_15_full",   64'(err_count),   64'd15);
        check("sat_err_15_narrow", 64'(s_err_count), 64'd15);
        step();
        for (int i = 0; i < 2; i++) do_verify(10'h000, 64'h1);
        check("sat_err_17_full",   64'(err_count),   64'd17);
        check("sat_err_17_narrow", 64'(s_err_count), 64'd15);
        check("sat_err_match",     64'(s_rsp_match), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
